// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared widths, FSM states and operand-pair layout for the multiplier sequencer
package mul_seq_pkg;
  localparam int DATA_W = 32;
  localparam int PROD_W = 64;
  localparam int PAIR_W = 2 * DATA_W;
  typedef enum logic [1:0] {IDLE, ISSUE, RUN, HOLD} state_t;
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } pair_t;
  function automatic logic has_zero(input pair_t p);
    return p.a == '0 || p.b == '0;
  endfunction
endpackage

// File: rtl/mul_seq_fifo.sv
// mul_seq_fifo: DEPTH-entry operand pair buffer; pointers wrap naturally since DEPTH is a power of two
module mul_seq_fifo import mul_seq_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [PAIR_W-1:0] din,
  output logic [PAIR_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);
  logic [PAIR_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  assign dout = mem[rd_ptr];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/mul_seq.sv
// mul_seq: queues operand pairs and drives an external multiplier one product at a time.
// Define MUL_SEQ_ZERO_BYPASS_EN to short-circuit pairs with a zero operand straight to HOLD.
module mul_seq import mul_seq_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              mul_beg,
  output logic [DATA_W-1:0] mul_a,
  output logic [DATA_W-1:0] mul_b,
  input  logic [PROD_W-1:0] mul_c,
  input  logic              mul_finish,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_c,
  output logic              busy
);
  state_t state, state_nx;
  pair_t head;
  logic [1:0] run_cnt;
  logic full, empty, push, pop, bypass, capture;
  assign in_ready = !RST && !full;
  assign push = in_valid && in_ready;
  assign mul_beg = state == RUN;
  assign out_valid = state == HOLD;
  assign busy = state != IDLE || !empty;
  mul_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(CLK),
    .rst(RST),
    .push(push),
    .pop(pop),
    .din({in_a, in_b}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
`ifdef MUL_SEQ_ZERO_BYPASS_EN
  assign bypass = has_zero(head);
`else
  assign bypass = 1'b0;
`endif
  // mul_finish may still be high from the previous product, so it is only trusted from the third RUN cycle
  always_comb begin
    state_nx = state;
    pop = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE: pop = !empty;
      ISSUE: state_nx = RUN;
      RUN: begin
        capture = mul_finish && run_cnt == 2'd2;
        state_nx = capture ? HOLD : RUN;
      end
      HOLD: begin
        pop = out_ready && !empty;
        state_nx = out_ready ? IDLE : HOLD;
      end
      default: state_nx = IDLE;
    endcase
    if (pop) state_nx = bypass ? HOLD : ISSUE;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      run_cnt <= '0;
      mul_a <= '0;
      mul_b <= '0;
      out_c <= '0;
    end else begin
      state <= state_nx;
      run_cnt <= state != RUN ? 2'd0 : run_cnt + 2'(run_cnt != 2'd2);
      if (pop) begin
        mul_a <= head.a;
        mul_b <= head.b;
      end
      if (capture || (pop && bypass)) out_c <= capture ? mul_c : '0;
    end
  end
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed and random checks of mul_seq against a queue-based product model
module tb_mul_seq;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [31:0] in_a = '0, in_b = '0;
  logic in_ready, mul_beg, mul_finish, out_valid, busy;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_c, out_c;
  int n_chk = 0, n_fail = 0;
  int lat = 18, bcnt = 0, cyc = 0;
  logic stale = 1'b0;
  int last_acc = 0, beg_rise = 0, ov_rise = 0, beg_cnt = 0, ov_cnt = 0, out_cnt = 0, acc_cnt = 0;
  logic acc = 1'b0, beg_prev = 1'b0, ov_prev = 1'b0, xfer_prev = 1'b0;
  logic [63:0] oc_prev = '0;
  logic [63:0] q[$];

  mul_seq dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_beg(mul_beg), .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c), .mul_finish(mul_finish),
    .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c), .busy(busy)
  );

  always #5 CLK = ~CLK;

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
    return 64'(longint'(int'(a)) * longint'(int'(b)));
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // multiplier model: product is valid once mul_beg has been high for lat cycles; in stale mode finish is stuck high
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    bcnt <= mul_beg ? bcnt + 1 : 0;
  end
  assign mul_finish = stale || (mul_beg && bcnt >= lat);
  assign mul_c = (mul_beg && bcnt >= (stale ? 2 : lat)) ? ref_prod(mul_a, mul_b) : 64'hBAD0_BAD0_BAD0_BAD0;

  always @(negedge CLK) begin
    acc <= in_valid && in_ready;
    if (RST) begin
      q.delete();
      beg_prev <= 1'b0;
      ov_prev <= 1'b0;
      xfer_prev <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        q.push_back(ref_prod(in_a, in_b));
        last_acc <= cyc;
        acc_cnt <= acc_cnt + 1;
      end
      if (mul_beg && !beg_prev) begin
        beg_rise <= cyc;
        beg_cnt <= beg_cnt + 1;
      end
      if (out_valid && !ov_prev) ov_rise <= cyc;
      if (out_valid) ov_cnt <= ov_cnt + 1;
      if (out_valid && ov_prev && !xfer_prev) chk("hold_stable", out_c, oc_prev);
      if (out_valid && out_ready) begin
        chk("sb_avail", 64'(q.size() == 0), 64'd0);
        if (q.size() != 0) chk("product", out_c, q.pop_front());
        out_cnt <= out_cnt + 1;
      end
      beg_prev <= mul_beg;
      ov_prev <= out_valid;
      xfer_prev <= out_valid && out_ready;
      oc_prev <= out_c;
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    int n;
    @(posedge CLK); #1;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    for (n = 0; n < 200; n++) begin
      @(negedge CLK);
      if (in_ready) break;
    end
    chk("tmo_push", 64'(n >= 200), 64'd0);
    @(posedge CLK); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_ov();
    int n;
    for (n = 0; n < 200; n++) begin
      @(negedge CLK); #1;
      if (out_valid) break;
    end
    chk("tmo_ov", 64'(n >= 200), 64'd0);
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 600; n++) begin
      @(negedge CLK); #1;
      if (!busy && !out_valid) break;
    end
    chk("tmo_idle", 64'(n >= 600), 64'd0);
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int base, bb;
    repeat (2) @(posedge CLK);
    @(negedge CLK); #1;
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_beg", 64'(mul_beg), 64'd0);
    chk("rst_outc", out_c, 64'd0);
    chk("rst_mula", 64'(mul_a), 64'd0);
    chk("rst_mulb", 64'(mul_b), 64'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK); #1;
    chk("post_rst_ready", 64'(in_ready), 64'd1);

    out_ready = 1'b1;
    lat = 18;
    push(32'd3, 32'hFFFF_FFFB);
    wait_ov();
    chk("single_lat", 64'(ov_rise - last_acc), 64'd22);
    chk("single_issue", 64'(beg_rise - last_acc), 64'd3);
    chk("single_outc", out_c, 64'hFFFF_FFFF_FFFF_FFF1);
    wait_idle();

    bb = beg_cnt;
    push(32'd0, 32'd7);
    wait_ov();
    chk("zero_outc", out_c, 64'd0);
`ifdef MUL_SEQ_ZERO_BYPASS_EN
    chk("zero_lat", 64'(ov_rise - last_acc), 64'd2);
    chk("zero_beg", 64'(beg_cnt - bb), 64'd0);
`else
    chk("zero_lat", 64'(ov_rise - last_acc), 64'd22);
    chk("zero_beg", 64'(beg_cnt - bb), 64'd1);
`endif
    wait_idle();

    lat = 5;
    base = out_cnt;
    push(32'd2, 32'd3);
    push(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push(32'h7FFF_FFFF, 32'd2);
    wait_idle();
    chk("order_cnt", 64'(out_cnt - base), 64'd3);

    out_ready = 1'b0;
    lat = 3;
    base = out_cnt;
    for (int i = 0; i < 5; i++) push($urandom, $urandom_range(1, 1000));
    wait_ov();
    repeat (5) @(negedge CLK);
    #1;
    chk("bp_ready", 64'(in_ready), 64'd0);
    chk("bp_busy", 64'(busy), 64'd1);
    chk("bp_valid", 64'(out_valid), 64'd1);
    @(posedge CLK); #1;
    out_ready = 1'b1;
    @(negedge CLK); #1;
    chk("bp_ready_hold", 64'(in_ready), 64'd0);
    @(negedge CLK); #1;
    chk("bp_ready_free", 64'(in_ready), 64'd1);
    wait_idle();
    chk("bp_cnt", 64'(out_cnt - base), 64'd5);

    stale = 1'b1;
    push(32'd12345, 32'hFFFF_FD5A);
    wait_ov();
    chk("stale_lat", 64'(ov_rise - beg_rise), 64'd3);
    chk("stale_outc", out_c, ref_prod(32'd12345, 32'hFFFF_FD5A));
    wait_idle();
    stale = 1'b0;

    lat = 30;
    for (int i = 0; i < 3; i++) push($urandom_range(1, 99), $urandom_range(1, 99));
    for (int n = 0; n < 100 && !mul_beg; n++) @(negedge CLK);
    chk("mid_run", 64'(mul_beg), 64'd1);
    base = ov_cnt;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK); #1;
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_ready", 64'(in_ready), 64'd1);
    repeat (50) @(negedge CLK);
    chk("mid_no_valid", 64'(ov_cnt - base), 64'd0);

    lat = $urandom_range(2, 9);
    base = acc_cnt;
    bb = out_cnt;
    for (int c = 0; c < 1500; c++) begin
      @(posedge CLK); #1;
      out_ready = $urandom_range(0, 2) != 0;
      if (!in_valid || acc) begin
        if (acc_cnt - base >= 40) in_valid = 1'b0;
        else begin
          in_valid = 1'($urandom_range(0, 1));
          in_a = rnd_op();
          in_b = rnd_op();
        end
      end
    end
    @(posedge CLK); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    chk("rnd_acc", 64'(acc_cnt - base), 64'd40);
    chk("rnd_out", 64'(out_cnt - bb), 64'd40);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 4, operand FIFO entries; power of two, 2 to 16.
REQ-002 SHALL have port CLK, input, 1 bit; the single clock, with all state updated on its rising edge.
REQ-003 SHALL have port RST, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have ports in_valid, in_ready (input, output, 1 bit each); operand-pair handshake.
REQ-005 SHALL have ports in_a and in_b, input, 32 bits each; multiplicand and multiplier.
REQ-006 SHALL have port mul_beg, output, 1 bit; drives the multiplier Beg input, where low restarts it and high lets it run.
REQ-007 SHALL have ports mul_a and mul_b, output, 32 bits each; operands presented to the multiplier.
REQ-008 SHALL have port mul_c, input, 64 bits; product from the multiplier.
REQ-009 SHALL have port mul_finish, input, 1 bit; multiplier done flag.
REQ-010 SHALL have ports out_valid, out_ready (output, input, 1 bit each); product handshake.
REQ-011 SHALL have port out_c, output, 64 bits; registered product.
REQ-012 SHALL have port busy, output, 1 bit; high when state is not IDLE or the FIFO is non-empty.

Function
REQ-013 SHALL buffer accepted pairs in a DEPTH-entry FIFO: push on in_valid&&in_ready; in_ready = (count < DEPTH), independent of same-cycle pop.
REQ-014 SHALL wrap FIFO read and write pointers modulo DEPTH and track count, 0 to DEPTH.
REQ-015 SHALL implement states IDLE, ISSUE, RUN and HOLD.
REQ-016 SHALL, in IDLE with the FIFO non-empty, pop the head into the mul_a/mul_b registers and enter ISSUE.
REQ-017 SHALL, in IDLE with the FIFO empty, remain in IDLE; a pair pushed into an empty FIFO is popped on the following cycle.
REQ-018 SHALL drive mul_beg=0 in IDLE and ISSUE, and mul_beg=1 only in RUN.
REQ-019 SHALL spend exactly one cycle in ISSUE, then enter RUN.
REQ-020 SHALL hold mul_a and mul_b stable from ISSUE through the end of RUN.
REQ-021 SHALL ignore mul_finish during the first 2 cycles of RUN; from then on, mul_finish sampled high captures mul_c into out_c and enters HOLD.
REQ-022 SHALL assert out_valid only in HOLD; out_c is stable while out_valid is high.
REQ-023 SHALL, in HOLD when out_ready=1, complete the transfer and go to IDLE, or go directly to pop-and-ISSUE if the FIFO is non-empty.
REQ-024 SHALL treat operands as 32-bit two's complement and pass the 64-bit product unchanged.
REQ-025 SHALL deliver products strictly in acceptance order, one product in flight.
REQ-026 SHALL never issue a second pair while in RUN or HOLD.

Reset
REQ-027 SHALL, while RST=1 on a clock edge, set: state IDLE, FIFO count and pointers 0, in_ready 0, out_valid 0, out_c 0, mul_a 0, mul_b 0, mul_beg 0, busy 0.
REQ-028 SHALL discard any in-flight multiply and all buffered pairs on a mid-operation RST; the product is never presented.
REQ-029 SHALL drive in_ready 1 from the first cycle after RST deasserts.

Configuration
REQ-030 SHALL, with MUL_SEQ_ZERO_BYPASS_EN defined, route a popped pair with in_a==0 or in_b==0 from IDLE/HOLD directly to HOLD with out_c=0, keeping mul_beg=0 so the multiplier is not started.
REQ-031 SHALL, without MUL_SEQ_ZERO_BYPASS_EN, send every pair, including zero operands, through ISSUE/RUN.

Structure
REQ-032 SHALL take the state enum, DATA_W=32 and PROD_W=64 from shared package mul_seq_pkg.
REQ-033 SHALL place the FIFO in sub-module mul_seq_fifo (parameter DEPTH, width 64 for the a/b pair).

Verification
REQ-034 Single pair: a=3, b=-5, model finish 18 cycles after mul_beg rises -> one ISSUE cycle with mul_beg=0; out_valid one cycle after finish; out_c=0xFFFF_FFFF_FFFF_FFF1.
REQ-035 Backpressure: push 5 pairs with out_ready=0, DEPTH=4 -> after the head pops, 4 more are buffered and in_ready=0 until HOLD completes.
REQ-036 Ordering: pairs (2,3),(−1,−1),(0x7FFFFFFF,2) with out_ready=1 -> outputs 6, 1, 0x0000_0000_FFFF_FFFE in order.
REQ-037 Stale finish: hold mul_finish=1 through the first 2 RUN cycles -> no capture until the 3rd RUN cycle.
REQ-038 Mid-run reset: RST for 1 cycle during RUN with 2 pairs queued -> out_valid never asserts; busy=0, in_ready=1 the next cycle.
REQ-039 Zero bypass: (0,7) with MUL_SEQ_ZERO_BYPASS_EN -> out_c=0, out_valid 1 cycle after pop, mul_beg never rises; without the macro -> full RUN, out_c=0.
